// File: rtl/axi_write_slave.sv
// AXI4 write-channel slave: one INCR burst in flight, legality checks, one B per burst.
// Optional byte strobes (WSTRB -> mem_be) are enabled by defining AXI_WSTRB_EN.
module axi_write_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         ARESTN,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic                         WVALID,
  input  logic                         WLAST,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata
`ifdef AXI_WSTRB_EN
  ,
  input  logic [DATA_WIDTH/8-1:0]      WSTRB,
  output logic [DATA_WIDTH/8-1:0]      mem_be
`endif
);

  localparam int          MAW       = $clog2(MEM_DEPTH);
  localparam int          SZ_SHIFT  = $clog2(DATA_WIDTH/8);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                  r_state;
  logic                    r_awready;
  logic                    r_wready;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_mem_we;
  logic [MAW-1:0]          r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [ADDR_WIDTH-1:0]   r_cur_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  logic [7:0]              r_beat_cnt;
  logic                    r_err;
`ifdef AXI_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] r_mem_be;
`endif

  logic [31:0] w_bytes;
  logic [31:0] w_page_end;
  logic [31:0] w_end;
  logic        w_aw_err;
  logic        w_last_cnt;
  logic        w_strb_ok;
  logic        w_wlast_err;

  // Burst extent computed 32 bits wide so no sum can wrap.
  assign w_bytes    = (32'(AWLEN) + 32'd1) << AWSIZE;
  assign w_page_end = 32'(AWADDR[11:0]) + w_bytes;
  assign w_end      = 32'(AWADDR) + w_bytes;
  assign w_aw_err   = (AWSIZE > 3'(SZ_SHIFT)) || (w_page_end > 32'd4096) || (w_end > MEM_BYTES);

  assign w_last_cnt  = (r_beat_cnt == r_len);
  assign w_wlast_err = (w_last_cnt != WLAST);

`ifdef AXI_WSTRB_EN
  assign w_strb_ok = |WSTRB;
  assign mem_be    = r_mem_be;
`else
  assign w_strb_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!ARESTN) begin
      r_state     <= S_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= 2'b00;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cur_addr  <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
`ifdef AXI_WSTRB_EN
      r_mem_be    <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_awready <= 1'b1;
          if (AWVALID && r_awready) begin
            r_cur_addr <= AWADDR;
            r_len      <= AWLEN;
            r_size     <= AWSIZE;
            r_beat_cnt <= '0;
            r_err      <= w_aw_err;
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (WVALID && r_wready) begin
            // The beat that raises err is still written; only later beats are suppressed.
            if (!r_err && w_strb_ok) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= MAW'(r_cur_addr >> SZ_SHIFT);
              r_mem_wdata <= WDATA;
`ifdef AXI_WSTRB_EN
              r_mem_be    <= WSTRB;
`endif
            end
            r_cur_addr <= r_cur_addr + (ADDR_WIDTH'(1) << r_size);
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_last_cnt || WLAST) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err || w_wlast_err) ? 2'b10 : 2'b00;
              r_err    <= r_err || w_wlast_err;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (r_bvalid && BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign AWREADY   = r_awready;
  assign WREADY    = r_wready;
  assign BVALID    = r_bvalid;
  assign BRESP     = r_bresp;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
